// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//
// Multi-cycle unsigned restoring divider. It computes one quotient bit per
// clock, taking the dividend MSB first. A nonzero-divisor operation runs for
// W cycles in RUN. It then spends one cycle in DONE and returns to IDLE.
// A zero divisor skips RUN. It goes straight to DONE with quotient = all
// ones, remainder = dividend and div_by_zero set.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; clears control and all registers
//   start        begin a division (accepted only in IDLE)
//   dividend     unsigned numerator, latched when start is accepted
//   divisor      unsigned denominator, latched when start is accepted
//   busy         high while iterating (RUN)
//   done         one-cycle pulse marking valid results (DONE)
//   quotient     unsigned quotient, held until the next accepted start
//   remainder    unsigned remainder, held until the next accepted start
//   div_by_zero  set with done when the latched divisor was 0; held until
//                the next accepted start
// -----------------------------------------------------------------------------
module restoring_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]     rem_acc;   // partial remainder between iterations
    logic [W-1:0]     dvd_sh;    // dividend shifts out MSB-first, quotient shifts in
    logic [W-1:0]     dsr;       // latched divisor
    logic [CNT_W-1:0] cnt;       // iteration counter

    logic [W:0]       acc_shift;
    logic [W:0]       acc_diff;
    logic             fits;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     sh_next;
    logic             last_iter;

    // One restoring step on a W+1 bit working value. The partial remainder
    // is always below the divisor. So acc_shift < 2*divisor, and the borrow
    // (bit W) of the full-width difference is exactly "acc_shift < divisor".
    // After a successful subtract the result is below the divisor again.
    // Its bit W is therefore always zero, and only W bits need storing.
    always_comb begin
        acc_shift = {rem_acc, dvd_sh[W-1]};
        acc_diff  = acc_shift - {1'b0, dsr};
        fits      = ~acc_diff[W];
        rem_next  = fits ? acc_diff[W-1:0] : acc_shift[W-1:0];
        sh_next   = {dvd_sh[W-2:0], fits};
        last_iter = (state == S_RUN) && (cnt == CNT_W'(W - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_acc     <= '0;
            dvd_sh      <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_sh      <= dividend;
                        dsr         <= divisor;
                        rem_acc     <= '0;
                        cnt         <= '0;
                        div_by_zero <= (divisor == '0);
                        // Zero divisor: results are known now, DONE is next.
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                S_RUN: begin
                    rem_acc <= rem_next;
                    dvd_sh  <= sh_next;
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient  <= sh_next;
                        remainder <= rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
